// File: rtl/li_relay_pkg.sv
// Shared types and helpers for the latency-insensitive relay chain.
package li_relay_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } li_rs_state_t;

  function automatic int li_occ_width(input int n);
    int w;
    w = $clog2(2 * n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [1:0] li_occ_contrib(input li_rs_state_t s);
    logic [1:0] c;
    case (s)
      EMPTY:   c = 2'd0;
      HALF:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/li_relay_stage.sv
// One capacity-2 relay station: main/aux registers with stop_up driven only by
// the state flop, so neither data nor stop has a combinational path through it.
module li_relay_stage
  import li_relay_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_up,
  input  logic             valid_up,
  output logic             stop_up,
  output logic [WIDTH-1:0] data_dn,
  output logic             valid_dn,
  input  logic             stop_dn,
  output logic [1:0]       occ_nxt
);

  li_rs_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic             accept_s;
  logic             drain_s;

  assign valid_dn = (state_q != EMPTY);
  assign stop_up  = (state_q == FULL);
  assign data_dn  = main_q;

  // Next-state and register-load selection for the three occupancy states.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    aux_d    = aux_q;
    accept_s = valid_up && (state_q != FULL);
    drain_s  = (state_q != EMPTY) && !stop_dn;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          main_d  = data_up;
          state_d = HALF;
        end else begin
          state_d = EMPTY;
        end
      end
      HALF: begin
        if (accept_s && drain_s) begin
          main_d = data_up;
        end else if (accept_s) begin
          aux_d   = data_up;
          state_d = FULL;
        end else if (drain_s) begin
          state_d = EMPTY;
        end else begin
          state_d = HALF;
        end
      end
      FULL: begin
        if (drain_s) begin
          main_d  = aux_q;
          state_d = HALF;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    occ_nxt = li_occ_contrib(state_d);
  end

  // Stage state and payload registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      aux_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      aux_q   <= aux_d;
    end
  end

endmodule

// File: rtl/li_relay_chain.sv
// Chain of N_STAGES relay stations (0 = wire pass-through) with live occupancy.
// Optional stall/high-water statistics are compiled in with LI_RELAY_STATS_EN.
module li_relay_chain
  import li_relay_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int N_STAGES    = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  in_link_data,
  input  logic                              in_link_valid,
  output logic                              in_link_stop,
  output logic [WIDTH-1:0]                  out_link_data,
  output logic                              out_link_valid,
  input  logic                              out_link_stop,
`ifdef LI_RELAY_STATS_EN
  output logic [STALL_CNT_W-1:0]            stall_cnt,
  output logic [li_occ_width(N_STAGES)-1:0] occ_hwm,
`endif
  output logic [li_occ_width(N_STAGES)-1:0] occupancy
);

  localparam int OCC_W = li_occ_width(N_STAGES);

  logic [OCC_W-1:0] occ_d;

  if (N_STAGES == 0) begin : g_wire
    assign out_link_data  = in_link_data;
    assign out_link_valid = in_link_valid;
    assign in_link_stop   = out_link_stop;
    assign occupancy      = '0;
    assign occ_d          = '0;
  end else begin : g_stages
    logic [WIDTH-1:0] lnk_data  [N_STAGES+1];
    logic             lnk_valid [N_STAGES+1];
    logic             lnk_stop  [N_STAGES+1];
    logic [1:0]       stage_occ [N_STAGES];
    logic [OCC_W-1:0] occ_sum;
    logic [OCC_W-1:0] occ_q;

    assign lnk_data[0]        = in_link_data;
    assign lnk_valid[0]       = in_link_valid;
    assign in_link_stop       = lnk_stop[0];
    assign out_link_data      = lnk_data[N_STAGES];
    assign out_link_valid     = lnk_valid[N_STAGES];
    assign lnk_stop[N_STAGES] = out_link_stop;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
      li_relay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .data_up  (lnk_data[i]),
        .valid_up (lnk_valid[i]),
        .stop_up  (lnk_stop[i]),
        .data_dn  (lnk_data[i+1]),
        .valid_dn (lnk_valid[i+1]),
        .stop_dn  (lnk_stop[i+1]),
        .occ_nxt  (stage_occ[i])
      );
    end

    // Sum next-state contributions so the registered count tracks the stage states.
    always_comb begin
      occ_sum = '0;
      for (int i = 0; i < N_STAGES; i++) begin
        occ_sum = occ_sum + OCC_W'(stage_occ[i]);
      end
    end

    // Registered occupancy.
    always_ff @(posedge clk) begin
      if (!reset) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_sum;
      end
    end

    assign occ_d     = occ_sum;
    assign occupancy = occ_q;
  end

`ifdef LI_RELAY_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [OCC_W-1:0]       hwm_q, hwm_d;

  // Saturating stall counter and occupancy high-water mark.
  always_comb begin
    if (out_link_valid && out_link_stop && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (occ_d > hwm_q) begin
      hwm_d = occ_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      hwm_q   <= hwm_d;
    end
  end

  assign stall_cnt = stall_q;
  assign occ_hwm   = hwm_q;
`endif

endmodule
